// File: rtl/ring_decoder.sv
// One-hot ring receiver: decodes the sampled ring to a binary index, flags non-one-hot and
// out-of-sequence samples, tracks lock with a HUNT/LOCKED FSM and counts faults (saturating).
module ring_decoder #(
    parameter int unsigned N          = 4,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [N-1:0]         ring_in,
    output logic [$clog2(N)-1:0] idx,
    output logic                 idx_valid,
    output logic                 onehot_err,
    output logic                 step_err,
    output logic                 locked,
    output logic [7:0]           err_count
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BW = $clog2(LOSS_COUNT + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic            prev_ok_q, prev_ok_d;
    logic [GW-1:0]   good_run_q, good_run_d;
    logic [BW-1:0]   bad_run_q, bad_run_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            idx_valid_q, idx_valid_d;
    logic            onehot_err_q, onehot_err_d;
    logic            step_err_q, step_err_d;
    logic [7:0]      err_count_q, err_count_d;

    logic            is_onehot;
    logic            rot_match;
    logic            good_step;
    logic            faulty;
    logic [N-1:0]    rot;
    logic [IW-1:0]   pos;

    // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
    always_comb begin
        is_onehot = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
        rot       = {prev_q[N-2:0], prev_q[N-1]};
        rot_match = (ring_in == rot);
        good_step = in_valid && is_onehot && prev_ok_q && rot_match;
        faulty    = in_valid && (!is_onehot || (prev_ok_q && !rot_match));
        pos       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ring_in[i]) pos = IW'(i);
        end
    end

    always_comb begin
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        step_err_d   = 1'b0;
        err_count_d  = err_count_q;

        if (in_valid) begin
            if (is_onehot) begin
                idx_d       = pos;
                idx_valid_d = 1'b1;
                prev_d      = ring_in;
                prev_ok_d   = 1'b1;
                step_err_d  = prev_ok_q && !rot_match;
            end else begin
                onehot_err_d = 1'b1;
                prev_ok_d    = 1'b0;
            end
        end

        if (good_step) begin
            if (good_run_q != GW'(LOCK_COUNT)) good_run_d = good_run_q + GW'(1);
            bad_run_d = '0;
        end else if (faulty) begin
            good_run_d = '0;
            if (bad_run_q != BW'(LOSS_COUNT)) bad_run_d = bad_run_q + BW'(1);
            if (err_count_q != '1) err_count_d = err_count_q + 8'd1;
        end else if (in_valid && is_onehot) begin
            good_run_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions look at the post-update run counts so the change lands with the causing sample.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:   if (good_step && good_run_d == GW'(LOCK_COUNT)) state_d = LOCKED;
            LOCKED: if (faulty && bad_run_d == BW'(LOSS_COUNT))     state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            step_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            step_err_q   <= step_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign onehot_err = onehot_err_q;
    assign step_err   = step_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed and random samples checked against an index-based model.
`timescale 1ns/1ps
module tb_ring_decoder;

    localparam int N    = 4;
    localparam int LOCK = 2;
    localparam int LOSS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [N-1:0] ring_in;
    logic [1:0]   idx;
    logic         idx_valid;
    logic         onehot_err;
    logic         step_err;
    logic         locked;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    // Model state, kept as ring positions rather than vectors.
    int m_idx, m_prev_k, m_good, m_bad, m_err;
    bit m_locked, m_iv, m_oh, m_se;

    ring_decoder #(.N(N), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .ring_in    (ring_in),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .onehot_err (onehot_err),
        .step_err   (step_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".idx"},        {30'd0, idx},        m_idx);
        chk({ctx, ".idx_valid"},  {31'd0, idx_valid},  {31'd0, m_iv});
        chk({ctx, ".onehot_err"}, {31'd0, onehot_err}, {31'd0, m_oh});
        chk({ctx, ".step_err"},   {31'd0, step_err},   {31'd0, m_se});
        chk({ctx, ".locked"},     {31'd0, locked},     {31'd0, m_locked});
        chk({ctx, ".err_count"},  {24'd0, err_count},  m_err);
    endtask

    task automatic model_reset();
        m_idx = 0; m_prev_k = -1; m_good = 0; m_bad = 0; m_err = 0;
        m_locked = 0; m_iv = 0; m_oh = 0; m_se = 0;
    endtask

    task automatic model_update(input bit v, input logic [N-1:0] vec);
        bit good, bad;
        int k;
        m_iv = 0; m_oh = 0; m_se = 0;
        good = 0; bad = 0;
        if (!v) return;
        if ($countones(vec) != 1) begin
            m_oh = 1; bad = 1; m_prev_k = -1;
        end else begin
            k = 0;
            for (int i = 0; i < N; i++) if (vec[i]) k = i;
            m_idx = k; m_iv = 1;
            if (m_prev_k < 0) m_good = 0;
            else if (k == (m_prev_k + 1) % N) good = 1;
            else begin m_se = 1; bad = 1; end
            m_prev_k = k;
        end
        if (good) begin
            m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1;
            m_bad = 0;
            if (!m_locked && m_good == LOCK) m_locked = 1;
        end
        if (bad) begin
            m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
            m_good = 0;
            m_bad = (m_bad + 1 > LOSS) ? LOSS : m_bad + 1;
            if (m_locked && m_bad == LOSS) m_locked = 0;
        end
    endtask

    task automatic step(input string ctx, input bit v, input logic [N-1:0] vec);
        in_valid = v;
        ring_in  = vec;
        @(posedge clk); #1;
        model_update(v, vec);
        check_all(ctx);
    endtask

    initial begin
        logic [N-1:0] vec;
        int r;
        reset = 1'b1; in_valid = 1'b0; ring_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Clean rotation with wrap-around; lock after the second good step.
        step("rot0", 1, 4'b0001);
        step("rot1", 1, 4'b0010);
        step("rot2", 1, 4'b0100);
        step("rot3", 1, 4'b1000);
        step("wrap", 1, 4'b0001);
        step("idle", 0, 4'b0010);

        // Non-one-hot samples, then a start sample.
        step("oh_a", 1, 4'b0110);
        step("oh_b", 1, 4'b0000);
        step("start", 1, 4'b0100);

        // Skip and hold.
        step("sk0", 1, 4'b0001);
        step("skip", 1, 4'b0100);
        step("hold", 1, 4'b0100);

        // Relock, single fault recovered, then two consecutive faults.
        step("rl0", 1, 4'b1000);
        step("rl1", 1, 4'b0001);
        step("rl2", 1, 4'b0010);
        step("f1", 1, 4'b1000);
        step("rec", 1, 4'b0001);
        step("f2a", 1, 4'b0001);
        step("f2b", 1, 4'b0001);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) step("sat", 1, 4'b0000);
        chk("sat_final", {24'd0, err_count}, 32'd255);

        // Async reset between edges.
        step("pre_rst", 1, 4'b0001);
        #3 reset = 1'b1; in_valid = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 reset = 1'b0;
        step("post_rst", 1, 4'b1000);
        step("post_rst2", 1, 4'b0001);

        // Random mix, biased toward correct rotations so lock is exercised.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6 && m_prev_k >= 0) vec = 4'(1 << ((m_prev_k + 1) % N));
            else if (r <= 7) vec = 4'(1 << $urandom_range(0, N - 1));
            else vec = 4'($urandom);
            step("rand", r != 9, vec);
        end

        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to the team's one-hot ring counter. Samples a rotating one-hot ring vector (shift toward MSB, MSB wraps to bit 0) on each qualified cycle, decodes it to a binary index, and checks that it is exactly one-hot and that each sample is one rotation step from the previous one. A small lock state machine reports when the ring is running cleanly, and a saturating error counter records faults for status readout.

## Interface
- N, default 4: ring width in bits, N >= 2; IW = $clog2(N).
- LOCK_COUNT, default 2: consecutive good steps needed to enter LOCKED (>= 1).
- LOSS_COUNT, default 2: consecutive faulty samples needed to leave LOCKED (>= 1).
- clk  input  1  sole clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  ring_in is sampled on this edge when high.
- ring_in  input  N  ring vector to check.
- idx  output  IW  binary position of the set bit from the last one-hot sample.
- idx_valid  output  1  one-cycle strobe: idx updated from a one-hot sample.
- onehot_err  output  1  one-cycle strobe: sampled vector not exactly one-hot.
- step_err  output  1  one-cycle strobe: one-hot sample is not the rotation of the previous one.
- locked  output  1  level: lock FSM in LOCKED.
- err_count  output  8  saturating count of faulty samples.

## Operation
- Internal state: prev (N bits), prev_ok (1), good_run, bad_run, FSM {HUNT, LOCKED}.
- Reset values: idx=0, idx_valid=0, onehot_err=0, step_err=0, locked=0, err_count=0, prev=0, prev_ok=0, good_run=0, bad_run=0, FSM=HUNT.
- Cycle with in_valid=0: all strobes 0; idx, locked, err_count, prev, prev_ok, and the run counters hold.
- Sample with in_valid=1 and popcount(ring_in) != 1 (includes all-zero):
  - onehot_err=1, idx_valid=0, idx holds.
  - prev_ok=0, so the next one-hot sample is not step-checked.
  - The sample is faulty.
- Sample with in_valid=1 and exactly one bit set at position k:
  - idx=k, idx_valid=1, prev=ring_in, prev_ok=1.
  - If prev_ok was 1 and ring_in != {prev[N-2:0], prev[N-1]}: step_err=1 and the sample is faulty. A hold (same vector repeated) and a skip are both step errors.
  - If prev_ok was 1 and ring_in matches the rotation: good step.
  - If prev_ok was 0: start sample; neither good nor faulty. good_run=0, bad_run unchanged.
- Good step: good_run increments, saturating at LOCK_COUNT; bad_run=0.
- Faulty sample: err_count increments, saturating at 255 (255 holds); good_run=0; bad_run increments, saturating at LOSS_COUNT.
- FSM transitions:
  - HUNT -> LOCKED when a good step makes good_run reach LOCK_COUNT.
  - LOCKED -> HUNT when a faulty sample makes bad_run reach LOSS_COUNT; good_run=0 on entering HUNT.
  - Otherwise the state holds. A single fault followed by a good step keeps LOCKED.
- Wrap-around: 1000 -> 0001 (N=4) is a good step.

## Timing
- All outputs are registered with 1-cycle latency: a sample on edge t is reflected on outputs after edge t, and the strobes are high for exactly the cycle between t and t+1.
- locked and err_count update on the same edge as the strobes for the sample that caused the change.
- Back-to-back in_valid is supported at full rate; no stalls.
- Asynchronous reset mid-stream: outputs go to their reset values without waiting for clk. The first one-hot sample after reset release is a start sample and raises no step_err.

## Test plan
- Reset, then on consecutive cycles feed 0001, 0010, 0100, 1000, 0001 -> idx 0,1,2,3,0 with idx_valid=1 each cycle one cycle later; no errors; locked=1 after the third sample (two good steps), stays 1; err_count=0.
- Locked stream, feed 0110 then 0000 -> onehot_err on both, idx_valid=0, idx holds; err_count=2; locked=0 after the second. Then feed 0100 -> idx=2 with no step_err (start sample).
- Feed 0001 then 0100 -> second sample: step_err=1, idx=2, idx_valid=1, err_count+1. Feed 0100 twice -> step_err on the repeat.
- Locked, one step error then 1-step-correct samples -> locked stays 1. With LOSS_COUNT=2, two consecutive errors -> locked=0 exactly after the second.
- Force 260 faulty samples -> err_count reaches 255 and holds at 255.
- Assert reset asynchronously between clock edges mid-stream -> all outputs 0 before the next edge. Release reset and feed 1000 -> idx=3, no step_err, locked=0.
